// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Purpose  : Bundle of every signal between mem_bus_arbiter and its two
//            masters (M0 = picorv32 native bus, M1 = UART boot/debug master)
//            and the single-port M10K RAM.
// Modports : slave  - the arbiter side (samples requests, drives RAM/status)
//            master - the system side (masters, RAM model, status observer)
// Signals  : i_mX_valid/addr/wdata/wstrb  request from master X
//            o_mX_ready/rdata             completion back to master X
//            o_ram_en/we/addr/wdata       RAM command, i_ram_rdata RAM data
//            o_grant/o_busy/o_bus_err/o_err_addr status
// Revision : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              i_m0_valid;
    logic [31:0]       i_m0_addr;
    logic [31:0]       i_m0_wdata;
    logic [3:0]        i_m0_wstrb;
    logic              o_m0_ready;
    logic [31:0]       o_m0_rdata;

    logic              i_m1_valid;
    logic [31:0]       i_m1_addr;
    logic [31:0]       i_m1_wdata;
    logic [3:0]        i_m1_wstrb;
    logic              o_m1_ready;
    logic [31:0]       o_m1_rdata;

    logic              o_ram_en;
    logic [3:0]        o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [31:0]       o_ram_wdata;
    logic [31:0]       i_ram_rdata;

    logic [1:0]        o_grant;
    logic              o_busy;
    logic              o_bus_err;
    logic [31:0]       o_err_addr;

    modport slave (
        input  i_m0_valid, i_m0_addr, i_m0_wdata, i_m0_wstrb,
        output o_m0_ready, o_m0_rdata,
        input  i_m1_valid, i_m1_addr, i_m1_wdata, i_m1_wstrb,
        output o_m1_ready, o_m1_rdata,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata,
        output o_grant, o_busy, o_bus_err, o_err_addr
    );

    modport master (
        output i_m0_valid, i_m0_addr, i_m0_wdata, i_m0_wstrb,
        input  o_m0_ready, o_m0_rdata,
        output i_m1_valid, i_m1_addr, i_m1_wdata, i_m1_wstrb,
        input  o_m1_ready, o_m1_rdata,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata,
        input  o_grant, o_busy, o_bus_err, o_err_addr
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master arbiter in front of a single-port synchronous RAM
//            with registered read. Each access runs IDLE->ISSUE->WAIT->RESP,
//            out-of-range accesses are suppressed and flagged, read data is
//            returned with a fixed latency and a one-cycle ready pulse.
// Ports    : i_clk_50mhz - system clock
//            i_reset     - asynchronous reset, active-high
//            bus         - mem_bus_arbiter_if.slave (masters, RAM, status)
// Params   : ADDR_W      - RAM word-address width (DEPTH = 2**ADDR_W)
//            FIXED_PRIO  - 0: round-robin on ties, 1: M0 always wins ties
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input wire               i_clk_50mhz,
    input wire               i_reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    logic [1:0]        r_state, w_state_nxt;

    // Registered outputs and their next values
    logic              r_ram_en,    w_ram_en_nxt;
    logic [3:0]        r_ram_we,    w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [31:0]       r_ram_wdata, w_ram_wdata_nxt;
    logic [1:0]        r_grant,     w_grant_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_m0_ready,  w_m0_ready_nxt;
    logic              r_m1_ready,  w_m1_ready_nxt;
    logic [31:0]       r_m0_rdata,  w_m0_rdata_nxt;
    logic [31:0]       r_m1_rdata,  w_m1_rdata_nxt;
    logic              r_bus_err,   w_bus_err_nxt;
    logic [31:0]       r_err_addr,  w_err_addr_nxt;

    // Command attributes that outlive the ISSUE cycle, plus tie pointer
    logic              r_cmd_in_range, w_cmd_in_range_nxt;
    logic              r_cmd_write,    w_cmd_write_nxt;
    logic              r_last_m1,      w_last_m1_nxt;

    // Request selection
    logic              w_any_req;
    logic              w_pick_m1;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wstrb;
    logic              w_sel_in_range;
    logic [31:0]       w_resp_data;

    assign w_any_req = bus.i_m0_valid | bus.i_m1_valid;

    // M1 wins when it is alone, or on a tie when round-robin says M0 had
    // the previous grant.
    assign w_pick_m1 = bus.i_m1_valid &
                       (~bus.i_m0_valid | (~FIXED_PRIO & ~r_last_m1));

    assign w_sel_addr     = w_pick_m1 ? bus.i_m1_addr  : bus.i_m0_addr;
    assign w_sel_wdata    = w_pick_m1 ? bus.i_m1_wdata : bus.i_m0_wdata;
    assign w_sel_wstrb    = w_pick_m1 ? bus.i_m1_wstrb : bus.i_m0_wstrb;
    assign w_sel_in_range = (w_sel_addr[31:ADDR_W+2] == '0);

    // Writes and out-of-range accesses always answer with zero
    assign w_resp_data = (r_cmd_in_range & ~r_cmd_write) ? bus.i_ram_rdata : 32'h0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: only IDLE waits, every other state lasts one cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  w_state_nxt = c_ST_RESP;
            c_ST_RESP:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs. The value
    // loaded on leaving a state is what the following state presents.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_en_nxt       = 1'b0;
        w_ram_we_nxt       = 4'h0;
        w_ram_addr_nxt     = r_ram_addr;
        w_ram_wdata_nxt    = r_ram_wdata;
        w_grant_nxt        = r_grant;
        w_busy_nxt         = r_busy;
        w_m0_ready_nxt     = 1'b0;
        w_m1_ready_nxt     = 1'b0;
        w_m0_rdata_nxt     = r_m0_rdata;
        w_m1_rdata_nxt     = r_m1_rdata;
        w_bus_err_nxt      = r_bus_err;
        w_err_addr_nxt     = r_err_addr;
        w_cmd_in_range_nxt = r_cmd_in_range;
        w_cmd_write_nxt    = r_cmd_write;
        w_last_m1_nxt      = r_last_m1;

        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt        = w_pick_m1 ? 2'b10 : 2'b01;
                    w_busy_nxt         = 1'b1;
                    w_last_m1_nxt      = w_pick_m1;
                    w_cmd_in_range_nxt = w_sel_in_range;
                    w_cmd_write_nxt    = |w_sel_wstrb;
                    // RAM command registers double as the captured request
                    w_ram_en_nxt       = w_sel_in_range;
                    w_ram_we_nxt       = w_sel_in_range ? w_sel_wstrb : 4'h0;
                    w_ram_addr_nxt     = w_sel_addr[ADDR_W+1:2];
                    w_ram_wdata_nxt    = w_sel_wdata;
                    if (!w_sel_in_range) begin
                        w_bus_err_nxt = 1'b1;
                        // Keep the address of the first offender only
                        if (!r_bus_err) begin
                            w_err_addr_nxt = w_sel_addr;
                        end
                    end
                end
            end
            c_ST_ISSUE: begin
                // RAM enable drops; read data arrives during WAIT
            end
            c_ST_WAIT: begin
                if (r_grant[1]) begin
                    w_m1_ready_nxt = 1'b1;
                    w_m1_rdata_nxt = w_resp_data;
                end else begin
                    w_m0_ready_nxt = 1'b1;
                    w_m0_rdata_nxt = w_resp_data;
                end
            end
            c_ST_RESP: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and command registers. The tie pointer resets to "M1 went
    // last" so that M0 wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_ram_en       <= 1'b0;
            r_ram_we       <= 4'h0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= 32'h0;
            r_grant        <= 2'b00;
            r_busy         <= 1'b0;
            r_m0_ready     <= 1'b0;
            r_m1_ready     <= 1'b0;
            r_m0_rdata     <= 32'h0;
            r_m1_rdata     <= 32'h0;
            r_bus_err      <= 1'b0;
            r_err_addr     <= 32'h0;
            r_cmd_in_range <= 1'b0;
            r_cmd_write    <= 1'b0;
            r_last_m1      <= 1'b1;
        end else begin
            r_ram_en       <= w_ram_en_nxt;
            r_ram_we       <= w_ram_we_nxt;
            r_ram_addr     <= w_ram_addr_nxt;
            r_ram_wdata    <= w_ram_wdata_nxt;
            r_grant        <= w_grant_nxt;
            r_busy         <= w_busy_nxt;
            r_m0_ready     <= w_m0_ready_nxt;
            r_m1_ready     <= w_m1_ready_nxt;
            r_m0_rdata     <= w_m0_rdata_nxt;
            r_m1_rdata     <= w_m1_rdata_nxt;
            r_bus_err      <= w_bus_err_nxt;
            r_err_addr     <= w_err_addr_nxt;
            r_cmd_in_range <= w_cmd_in_range_nxt;
            r_cmd_write    <= w_cmd_write_nxt;
            r_last_m1      <= w_last_m1_nxt;
        end
    end

    assign bus.o_ram_en    = r_ram_en;
    assign bus.o_ram_we    = r_ram_we;
    assign bus.o_ram_addr  = r_ram_addr;
    assign bus.o_ram_wdata = r_ram_wdata;
    assign bus.o_grant     = r_grant;
    assign bus.o_busy      = r_busy;
    assign bus.o_m0_ready  = r_m0_ready;
    assign bus.o_m1_ready  = r_m1_ready;
    assign bus.o_m0_rdata  = r_m0_rdata;
    assign bus.o_m1_rdata  = r_m1_rdata;
    assign bus.o_bus_err   = r_bus_err;
    assign bus.o_err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter. dut_a (round-robin)
//            runs a table of single transactions against a byte-writable
//            RAM model; dut_b (fixed priority) is used for the tie-break
//            sequence. Hand-written sequences cover reset during WAIT and
//            continuous contention.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus_a ();
    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus_b ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b0)) dut_a (
        .i_clk_50mhz (clk),
        .i_reset     (rst),
        .bus         (bus_a)
    );

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b1)) dut_b (
        .i_clk_50mhz (clk),
        .i_reset     (rst),
        .bus         (bus_b)
    );

    // RAM model for dut_a: byte writes, registered read (old data on read)
    logic [31:0] mem_a [0:255];
    logic        mem_clr  = 1'b0;
    logic        pre_en   = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
        end else begin
            if (pre_en) mem_a[pre_addr] <= pre_data;
            if (bus_a.o_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus_a.o_ram_we[b])
                        mem_a[bus_a.o_ram_addr][b*8 +: 8] <= bus_a.o_ram_wdata[b*8 +: 8];
                bus_a.i_ram_rdata <= mem_a[bus_a.o_ram_addr];
            end
        end
    end

    // dut_b RAM returns the word index, enough to tell accesses apart
    always @(posedge clk) begin
        if (bus_b.o_ram_en) bus_b.i_ram_rdata <= {24'h0, bus_b.o_ram_addr};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant"},    {30'h0, bus_a.o_grant}, 32'h0);
        check({tag, " busy"},     {31'h0, bus_a.o_busy}, 32'h0);
        check({tag, " m0_ready"}, {31'h0, bus_a.o_m0_ready}, 32'h0);
        check({tag, " m1_ready"}, {31'h0, bus_a.o_m1_ready}, 32'h0);
        check({tag, " m0_rdata"}, bus_a.o_m0_rdata, 32'h0);
        check({tag, " m1_rdata"}, bus_a.o_m1_rdata, 32'h0);
        check({tag, " ram_en"},   {31'h0, bus_a.o_ram_en}, 32'h0);
        check({tag, " ram_we"},   {28'h0, bus_a.o_ram_we}, 32'h0);
        check({tag, " ram_addr"}, {24'h0, bus_a.o_ram_addr}, 32'h0);
        check({tag, " ram_wdata"}, bus_a.o_ram_wdata, 32'h0);
        check({tag, " bus_err"},  {31'h0, bus_a.o_bus_err}, 32'h0);
        check({tag, " err_addr"}, bus_a.o_err_addr, 32'h0);
    endtask

    typedef struct {
        logic        m1;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [7:0]  exp_ram_addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_err_addr;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] last_rd [2];

    // One complete transaction on dut_a. The request is scrambled and
    // dropped right after the grant edge; the captured one must still run.
    task automatic run_txn(input vec_t v, input int idx);
        string       p;
        logic        rdy_g, rdy_o;
        logic [31:0] rd_g, rd_o;
        p = $sformatf("v%0d", idx);
        if (v.m1) begin
            bus_a.i_m1_valid = 1'b1; bus_a.i_m1_addr = v.addr;
            bus_a.i_m1_wdata = v.wdata; bus_a.i_m1_wstrb = v.wstrb;
        end else begin
            bus_a.i_m0_valid = 1'b1; bus_a.i_m0_addr = v.addr;
            bus_a.i_m0_wdata = v.wdata; bus_a.i_m0_wstrb = v.wstrb;
        end
        tick();
        // ISSUE
        if (v.m1) begin
            bus_a.i_m1_valid = 1'b0; bus_a.i_m1_addr = 32'hFFFF_FFFF;
            bus_a.i_m1_wdata = ~v.wdata; bus_a.i_m1_wstrb = 4'hF;
        end else begin
            bus_a.i_m0_valid = 1'b0; bus_a.i_m0_addr = 32'hFFFF_FFFF;
            bus_a.i_m0_wdata = ~v.wdata; bus_a.i_m0_wstrb = 4'hF;
        end
        check({p, " issue grant"}, {30'h0, bus_a.o_grant}, v.m1 ? 32'h2 : 32'h1);
        check({p, " issue busy"},  {31'h0, bus_a.o_busy}, 32'h1);
        check({p, " issue ram_en"}, {31'h0, bus_a.o_ram_en}, {31'h0, v.exp_en});
        check({p, " issue ram_we"}, {28'h0, bus_a.o_ram_we}, {28'h0, v.exp_we});
        if (v.exp_en) begin
            check({p, " issue ram_addr"}, {24'h0, bus_a.o_ram_addr}, {24'h0, v.exp_ram_addr});
            if (v.exp_we != 4'h0)
                check({p, " issue ram_wdata"}, bus_a.o_ram_wdata, v.wdata);
        end
        tick();
        // WAIT
        rdy_g = v.m1 ? bus_a.o_m1_ready : bus_a.o_m0_ready;
        check({p, " wait ram_en"}, {31'h0, bus_a.o_ram_en}, 32'h0);
        check({p, " wait ready"},  {31'h0, rdy_g}, 32'h0);
        tick();
        // RESP
        rdy_g = v.m1 ? bus_a.o_m1_ready : bus_a.o_m0_ready;
        rdy_o = v.m1 ? bus_a.o_m0_ready : bus_a.o_m1_ready;
        rd_g  = v.m1 ? bus_a.o_m1_rdata : bus_a.o_m0_rdata;
        rd_o  = v.m1 ? bus_a.o_m0_rdata : bus_a.o_m1_rdata;
        check({p, " resp ready"},       {31'h0, rdy_g}, 32'h1);
        check({p, " resp rdata"},       rd_g, v.exp_rdata);
        check({p, " resp other ready"}, {31'h0, rdy_o}, 32'h0);
        check({p, " resp other rdata"}, rd_o, last_rd[v.m1 ? 0 : 1]);
        last_rd[v.m1 ? 1 : 0] = v.exp_rdata;
        tick();
        // IDLE again
        rdy_g = v.m1 ? bus_a.o_m1_ready : bus_a.o_m0_ready;
        rd_g  = v.m1 ? bus_a.o_m1_rdata : bus_a.o_m0_rdata;
        check({p, " idle ready"},    {31'h0, rdy_g}, 32'h0);
        check({p, " idle grant"},    {30'h0, bus_a.o_grant}, 32'h0);
        check({p, " idle busy"},     {31'h0, bus_a.o_busy}, 32'h0);
        check({p, " idle rdata"},    rd_g, v.exp_rdata);
        check({p, " bus_err"},       {31'h0, bus_a.o_bus_err}, {31'h0, v.exp_err});
        check({p, " err_addr"},      bus_a.o_err_addr, v.exp_err_addr);
    endtask

    int          ord_a [4], cyc_a [4], ord_b [4], cyc_b [4];
    logic [31:0] rd_a [4], rd_b [4];
    int          na, nb;

    initial begin
        //            m1    addr          wdata         wstrb en    we    ra     rdata         err   err_addr
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b1, 4'h0, 8'd4,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h11223344, 4'h4, 1'b1, 4'h4, 8'd8,   32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 1'b1, 4'h0, 8'd8,   32'h00220000, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0013, 32'h0,        4'h0, 1'b1, 4'h0, 8'd4,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_03FC, 32'hCAFEF00D, 4'hF, 1'b1, 4'hF, 8'd255, 32'h0,        1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_03FF, 32'h0,        4'h0, 1'b1, 4'h0, 8'd255, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0400, 32'h0,        4'h0, 1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 32'h400};
        vecs[7] = '{1'b1, 32'h0000_0800, 32'h5555AAAA, 4'hF, 1'b0, 4'h0, 8'd0,   32'h0,        1'b1, 32'h400};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 1'b1, 4'h0, 8'd0,   32'h0,        1'b1, 32'h400};
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        bus_a.i_m0_valid = 1'b0; bus_a.i_m0_addr = 32'h0; bus_a.i_m0_wdata = 32'h0; bus_a.i_m0_wstrb = 4'h0;
        bus_a.i_m1_valid = 1'b0; bus_a.i_m1_addr = 32'h0; bus_a.i_m1_wdata = 32'h0; bus_a.i_m1_wstrb = 4'h0;
        bus_b.i_m0_valid = 1'b0; bus_b.i_m0_addr = 32'h0; bus_b.i_m0_wdata = 32'h0; bus_b.i_m0_wstrb = 4'h0;
        bus_b.i_m1_valid = 1'b0; bus_b.i_m1_addr = 32'h0; bus_b.i_m1_wdata = 32'h0; bus_b.i_m1_wstrb = 4'h0;

        // Reset while clearing and preloading the RAM model
        mem_clr = 1'b1;
        tick(); tick();
        mem_clr = 1'b0;
        pre_en = 1'b1; pre_addr = 8'd4; pre_data = 32'hDEADBEEF;
        tick();
        pre_en = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Reset asserted during WAIT of an M1 read
        bus_a.i_m1_valid = 1'b1; bus_a.i_m1_addr = 32'h10; bus_a.i_m1_wstrb = 4'h0;
        tick();
        tick();
        bus_a.i_m1_valid = 1'b0;
        #3 rst = 1'b1;
        #1 check_all_zero("midreset");
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("postreset m1_ready c%0d", i), {31'h0, bus_a.o_m1_ready}, 32'h0);
        end

        // Continuous contention on both DUTs
        bus_a.i_m0_valid = 1'b1; bus_a.i_m0_addr = 32'h10; bus_a.i_m0_wstrb = 4'h0;
        bus_a.i_m1_valid = 1'b1; bus_a.i_m1_addr = 32'h20; bus_a.i_m1_wstrb = 4'h0;
        bus_b.i_m0_valid = 1'b1; bus_b.i_m0_addr = 32'h10; bus_b.i_m0_wstrb = 4'h0;
        bus_b.i_m1_valid = 1'b1; bus_b.i_m1_addr = 32'h20; bus_b.i_m1_wstrb = 4'h0;
        na = 0; nb = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (na < 4 && (bus_a.o_m0_ready || bus_a.o_m1_ready)) begin
                ord_a[na] = bus_a.o_m1_ready ? 1 : 0;
                cyc_a[na] = c;
                rd_a[na]  = bus_a.o_m1_ready ? bus_a.o_m1_rdata : bus_a.o_m0_rdata;
                na++;
            end
            if (nb < 4 && (bus_b.o_m0_ready || bus_b.o_m1_ready)) begin
                ord_b[nb] = bus_b.o_m1_ready ? 1 : 0;
                cyc_b[nb] = c;
                rd_b[nb]  = bus_b.o_m1_ready ? bus_b.o_m1_rdata : bus_b.o_m0_rdata;
                nb++;
            end
        end
        bus_a.i_m0_valid = 1'b0; bus_a.i_m1_valid = 1'b0;
        bus_b.i_m0_valid = 1'b0; bus_b.i_m1_valid = 1'b0;

        check("rr response count", na, 4);
        check("fixed response count", nb, 4);
        for (int k = 0; k < na; k++) begin
            check($sformatf("rr order %0d", k), ord_a[k], k % 2);
            check($sformatf("rr cycle %0d", k), cyc_a[k], 2 + 4 * k);
            check($sformatf("rr rdata %0d", k), rd_a[k], (k % 2 == 1) ? 32'h00220000 : 32'hDEADBEEF);
        end
        for (int k = 0; k < nb; k++) begin
            check($sformatf("fixed order %0d", k), ord_b[k], 0);
            check($sformatf("fixed cycle %0d", k), cyc_b[k], 2 + 4 * k);
            check($sformatf("fixed rdata %0d", k), rd_b[k], 32'h4);
        end

        tick(); tick(); tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
